// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: select/address inputs and registered sequencer outputs
interface micro_sequencer_if #(parameter int AW = 8);
   logic          M0;
   logic          M1;
   logic [AW-1:0] enc_addr;
   logic [AW-1:0] pipe_addr;
   logic          moc_wait;
   logic [AW-1:0] state;
   logic [AW-1:0] inc_state;
   logic [1:0]    sel_q;
   logic [3:0]    hold_cnt;
   logic          timeout;
   modport master (
      output M0, M1, enc_addr, pipe_addr, moc_wait,
      input  state, inc_state, sel_q, hold_cnt, timeout
   );
   modport slave (
      input  M0, M1, enc_addr, pipe_addr, moc_wait,
      output state, inc_state, sel_q, hold_cnt, timeout
   );
endinterface

// File: rtl/micro_sequencer.sv
// micro_sequencer: microaddress register with 4-way next-address select, memory-wait hold and stuck timeout
module micro_sequencer #(
   parameter int AW         = 8,
   parameter int RESET_ADDR = 0,
   parameter int FETCH_ADDR = 1,
   parameter int TIMEOUT    = 15
) (
   input logic              clk,
   input logic              reset,
   micro_sequencer_if.slave bus
);
   localparam logic [AW-1:0] RST_A   = AW'(RESET_ADDR);
   localparam logic [AW-1:0] FETCH_A = AW'(FETCH_ADDR);
   logic [1:0]    sel;
   logic [AW-1:0] nxt_addr;
   logic [3:0]    hold_nxt;
   logic          hit;
   always_comb begin
      sel      = {bus.M1, bus.M0};
      nxt_addr = sel == 2'b00 ? bus.enc_addr :
                 sel == 2'b01 ? FETCH_A :
                 sel == 2'b10 ? bus.pipe_addr : bus.inc_state;
      hold_nxt = !bus.moc_wait ? 4'd0 :
                 bus.hold_cnt == 4'hF ? bus.hold_cnt : bus.hold_cnt + 4'd1;
      hit      = bus.moc_wait && int'(hold_nxt) == TIMEOUT;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.state     <= RST_A;
         bus.inc_state <= RST_A + AW'(1);
         bus.sel_q     <= 2'b00;
         bus.hold_cnt  <= 4'd0;
         bus.timeout   <= 1'b0;
      end else begin
         bus.hold_cnt <= hold_nxt;
         if (hit) bus.timeout <= 1'b1;
         if (!bus.moc_wait) begin
            bus.state     <= nxt_addr;
            bus.inc_state <= nxt_addr + AW'(1);
            bus.sel_q     <= sel;
         end
      end
   end
endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 The module SHALL provide parameter AW, default 8, meaning the control-store address width.
REQ-002 The module SHALL provide parameter RESET_ADDR, default 0, meaning the microaddress loaded on reset.
REQ-003 The module SHALL provide parameter FETCH_ADDR, default 1, meaning the microaddress of the fetch microroutine.
REQ-004 The module SHALL provide parameter TIMEOUT, default 15, meaning the consecutive hold cycles that flag a stuck memory operation.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 M0  input  1  next-state select bit 0 from the next-state selector.
REQ-008 M1  input  1  next-state select bit 1 from the next-state selector.
REQ-009 enc_addr  input  AW  microaddress from the instruction encoder.
REQ-010 pipe_addr  input  AW  target-address field of the current microinstruction.
REQ-011 moc_wait  input  1  memory operation not complete; freezes sequencing while high.
REQ-012 state  output  AW  current microaddress driven to the control store.
REQ-013 inc_state  output  AW  registered state+1, the incrementer path.
REQ-014 sel_q  output  2  registered {M1,M0} used for the most recent state load (diagnostic).
REQ-015 hold_cnt  output  4  consecutive cycles held by moc_wait.
REQ-016 timeout  output  1  sticky flag; hold_cnt reached TIMEOUT.

Function
REQ-017 The select decode SHALL be {M1,M0}: 00 -> enc_addr, 01 -> FETCH_ADDR, 10 -> pipe_addr, 11 -> inc_state.
REQ-018 When moc_wait is low and reset is low, state SHALL load the selected address on the clock edge; the new value is visible one cycle after the select is presented.
REQ-019 inc_state SHALL be loaded on the same edge with (selected address + 1) modulo 2^AW, so inc_state always equals state+1 after any load.
REQ-020 Increment SHALL wrap: a loaded address of all-ones gives inc_state = 0, with no flag.
REQ-021 Selecting 11 repeatedly SHALL advance state by exactly 1 per unheld cycle.
REQ-022 sel_q SHALL capture {M1,M0} on every load edge and hold otherwise.
REQ-023 While moc_wait is high, state, inc_state and sel_q SHALL hold their values regardless of M0, M1, enc_addr and pipe_addr.
REQ-024 hold_cnt SHALL increment each cycle moc_wait is high, saturate at 15, and clear to 0 on the first cycle moc_wait is low.
REQ-025 timeout SHALL set on the edge where hold_cnt would reach TIMEOUT and remain set until reset; it does not block sequencing.
REQ-026 The select inputs SHALL be sampled only at the clock edge; input changes between edges have no effect on outputs.
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-028 When reset is high at an edge, state = RESET_ADDR, inc_state = RESET_ADDR+1, sel_q = 00, hold_cnt = 0, timeout = 0.
REQ-029 Reset SHALL take priority over moc_wait and any select, including when asserted in the middle of a hold.
REQ-030 On the first edge after reset deasserts, the sequencer SHALL load normally from the presented select.

Verification
REQ-031 Reset, then {M1,M0}=01 with moc_wait=0 for one cycle -> state=1, inc_state=2, sel_q=01.
REQ-032 state=1, then {M1,M0}=00 with enc_addr=0x40, then 11 for three cycles -> state 0x40, 0x41, 0x42, 0x43.
REQ-033 {M1,M0}=10 with pipe_addr=0xFF, then 11 -> state=0xFF with inc_state=0x00, then state=0x00 with inc_state=0x01.
REQ-034 state=0x20, moc_wait high for 5 cycles while selects toggle -> state stays 0x20, hold_cnt counts 1..5, then clears to 0 and the next load happens on the first low cycle.
REQ-035 moc_wait high for 20 cycles -> timeout rises on the 15th held edge, hold_cnt saturates at 15, and timeout stays 1 after moc_wait drops.
REQ-036 Reset asserted on the 3rd cycle of a hold -> all outputs return to their reset values on that edge, and timeout is cleared.
